// File: rtl/data_pipe_nto1_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : data_pipe_nto1_if                                         |
// | Purpose  : Wide-word write side and narrow-slice read side of the    |
// |            N-to-1 width splitter, bundled with master/slave views.   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface data_pipe_nto1_if #(
  parameter int DSIZE = 1,
  parameter int NSIZE = 8
);
  localparam int NW = $clog2(NSIZE);

  logic [DSIZE*NSIZE-1:0] wr_data;
  logic                   wr_vld;
  logic                   wr_ready;
  logic [NW-1:0]          wr_num;
  logic [DSIZE-1:0]       rd_data;
  logic                   rd_vld;
  logic                   rd_ready;
  logic                   rd_align_last;

  // Upstream producer / downstream consumer side.
  modport master (
    output wr_data, wr_vld, wr_num, rd_ready,
    input  wr_ready, rd_data, rd_vld, rd_align_last
  );

  // Splitter side.
  modport slave (
    input  wr_data, wr_vld, wr_num, rd_ready,
    output wr_ready, rd_data, rd_vld, rd_align_last
  );
endinterface
`default_nettype wire

// File: rtl/data_pipe_nto1.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : data_pipe_nto1                                            |
// | Purpose  : Width splitter. Loads one word of NSIZE slices and emits  |
// |            the slices one per valid/ready handshake, with optional   |
// |            partial words (wr_num) and an end-of-word marker.         |
// |            Define DATA_PIPE_NTO1_LSB_FIRST_EN to emit the lowest     |
// |            slice first instead of the highest.                       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module data_pipe_nto1 #(
  parameter int DSIZE = 1,
  parameter int NSIZE = 8
) (
  input  logic             clock,
  input  logic             rst,
  data_pipe_nto1_if.slave  bus
);

  localparam int NW = $clog2(NSIZE);
  localparam int C_W = DSIZE * NSIZE;
  localparam logic [NW:0] C_FULL_CNT = (NW+1)'(NSIZE);
  localparam logic [NW:0] C_ONE_CNT  = (NW+1)'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [C_W-1:0]  r_sreg,  w_sreg_nxt;
  logic [NW:0]     r_cnt,   w_cnt_nxt;

  logic            w_busy;
  logic            w_last;
  logic            w_load;
  logic [NW:0]     w_load_cnt;

  assign w_busy = (r_state == SHIFT);
  assign w_last = (r_cnt == C_ONE_CNT);

  // The only combinational path: the final slice being taken frees the slot.
  assign bus.wr_ready      = !w_busy || (bus.rd_ready && w_last);
  assign bus.rd_vld        = w_busy;
  assign bus.rd_align_last = w_busy && w_last;

`ifdef DATA_PIPE_NTO1_LSB_FIRST_EN
  assign bus.rd_data = r_sreg[DSIZE-1:0];
`else
  assign bus.rd_data = r_sreg[C_W-1 -: DSIZE];
`endif

  // Gate on wr_vld so undefined data never reaches the shift register.
  assign w_load = bus.wr_vld && bus.wr_ready;

  // Zero or out-of-range counts mean a full word.
  assign w_load_cnt = ((bus.wr_num == '0) || ({1'b0, bus.wr_num} >= C_FULL_CNT))
                      ? C_FULL_CNT : {1'b0, bus.wr_num};

  // State, shift register and slice counter, cleared asynchronously.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sreg  <= w_sreg_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: load takes priority (covers the back-to-back refill on the last slice).
  always_comb begin
    w_state_nxt = r_state;
    w_sreg_nxt  = r_sreg;
    w_cnt_nxt   = r_cnt;
    if (w_load) begin
      w_state_nxt = SHIFT;
      w_sreg_nxt  = bus.wr_data;
      w_cnt_nxt   = w_load_cnt;
    end else if (w_busy && bus.rd_ready) begin
      if (w_last) begin
        w_state_nxt = IDLE;
      end else begin
`ifdef DATA_PIPE_NTO1_LSB_FIRST_EN
        w_sreg_nxt = r_sreg >> DSIZE;
`else
        w_sreg_nxt = r_sreg << DSIZE;
`endif
        w_cnt_nxt  = r_cnt - C_ONE_CNT;
      end
    end
  end

endmodule
`default_nettype wire
